// File: rtl/shift_result_stage.sv
// Registered result/flag stage behind the 8-bit shifter: captures each shift result with
// its zero/negative/carry flags and queues it in a small FIFO for writeback.
module shift_result_stage #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3,
  parameter int RDW   = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_operand,
  input  logic [WIDTH-1:0] in_result,
  input  logic [SHW-1:0]   in_amount,
  input  logic             in_left,
  input  logic             in_arith,
  input  logic [RDW-1:0]   in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [RDW-1:0]   out_rd,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = WIDTH + RDW + 3;

  // Entry layout: {carry, neg, zero, rd, data}
  logic [EW-1:0]  mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic           push, pop;
  logic           in_carry;
  logic [SHW-1:0] left_idx, right_idx;
  logic [EW-1:0]  in_entry;
  logic [EW-1:0]  head;

  // Handshake: a transfer happens on a rising edge where valid && ready; ready never
  // depends on the consumer side, so a full stage refuses input even while draining.
  assign in_ready  = !reset && (count_q < (PW+1)'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // in_arith does not affect carry: for any right shift the last bit out is operand[amount-1].
  assign left_idx  = SHW'(WIDTH - int'(in_amount));
  assign right_idx = in_amount - SHW'(1);

  always_comb begin
    in_carry = 1'b0;
    if (in_amount != '0) begin
      if (in_left) in_carry = in_operand[left_idx];
      else         in_carry = in_operand[right_idx];
    end
  end

  assign in_entry = {in_carry, in_result[WIDTH-1], (in_result == '0), in_rd, in_result};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && !flush) mem_q[wr_ptr_q] <= in_entry;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_data  = head[WIDTH-1:0];
  assign out_rd    = head[WIDTH +: RDW];
  assign out_zero  = head[WIDTH+RDW];
  assign out_neg   = head[WIDTH+RDW+1];
  assign out_carry = head[WIDTH+RDW+2];

endmodule

// File: tb/tb_shift_result_stage.sv
// Directed and randomized bench for shift_result_stage against a queue-based reference model.
module tb_shift_result_stage;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;
  localparam int RDW   = 4;
  localparam int DEPTH = 2;
  localparam int W     = WIDTH + RDW + 3;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready;
  logic [WIDTH-1:0] in_operand, in_result;
  logic [SHW-1:0]   in_amount;
  logic             in_left, in_arith;
  logic [RDW-1:0]   in_rd;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_data;
  logic [RDW-1:0]   out_rd;
  logic             out_zero, out_neg, out_carry;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Expected FIFO contents, each packed as {carry, neg, zero, rd, data}
  logic [W-1:0] exp_q[$];

  shift_result_stage #(.WIDTH(WIDTH), .SHW(SHW), .RDW(RDW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_operand(in_operand), .in_result(in_result), .in_amount(in_amount),
    .in_left(in_left), .in_arith(in_arith), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd),
    .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Last bit pushed out of the operand, from plain integer arithmetic on the shift.
  function automatic logic ref_carry(input int op, input int amt, input logic left);
    if (amt == 0) return 1'b0;
    if (left) return 1'(((op << amt) >> WIDTH) & 1);
    return 1'(((op >> (amt - 1)) & 1));
  endfunction

  function automatic logic [W-1:0] ref_entry();
    logic c, n, z;
    c = ref_carry(int'(in_operand), int'(in_amount), in_left);
    n = (int'(in_result) >= (1 << (WIDTH - 1)));
    z = (int'(in_result) == 0);
    return {c, n, z, in_rd, in_result};
  endfunction

  task automatic check_outputs(input string tag);
    logic [W-1:0] e;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(!reset && exp_q.size() < DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check({tag, ".out_data"}, 32'(out_data), 32'(e[WIDTH-1:0]));
      check({tag, ".out_rd"}, 32'(out_rd), 32'(e[WIDTH +: RDW]));
      check({tag, ".out_zero"}, 32'(out_zero), 32'(e[WIDTH+RDW]));
      check({tag, ".out_neg"}, 32'(out_neg), 32'(e[WIDTH+RDW+1]));
      check({tag, ".out_carry"}, 32'(out_carry), 32'(e[WIDTH+RDW+2]));
    end
  endtask

  // One clock: decide transfers from the model, advance it, then compare just after the edge.
  task automatic tick(input string tag);
    logic         push, pop;
    logic [W-1:0] e;
    push = in_valid && !reset && (exp_q.size() < DEPTH);
    pop  = (exp_q.size() != 0) && out_ready;
    e    = ref_entry();
    @(posedge clk);
    #1;
    if (reset || flush) exp_q.delete();
    else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(e);
    end
    check_outputs(tag);
  endtask

  task automatic drive(input logic [7:0] op, input logic [7:0] res, input logic [2:0] amt,
                       input logic left, input logic arith, input logic [3:0] rd);
    in_valid = 1'b1; in_operand = op; in_result = res;
    in_amount = amt; in_left = left; in_arith = arith; in_rd = rd;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] op, res;
    logic [2:0] amt;
    logic       lf, ar;

    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_operand = '0; in_result = '0; in_amount = '0;
    in_left = 1'b0; in_arith = 1'b0; in_rd = '0;
    tick("reset0");
    tick("reset1");
    reset = 1'b0;
    #1;
    check("rel.in_ready", 32'(in_ready), 32'd1);
    check("rel.out_valid", 32'(out_valid), 32'd0);
    check("rel.out_data", 32'(out_data), 32'h00);
    check("rel.out_rd", 32'(out_rd), 32'h0);
    check("rel.flags", 32'({out_zero, out_neg, out_carry}), 32'd0);

    drive(8'hB4, 8'h40, 3'd3, 1'b1, 1'b0, 4'd5);
    tick("left");
    idle();
    check("left.data", 32'(out_data), 32'h40);
    check("left.rd", 32'(out_rd), 32'd5);
    check("left.flags", 32'({out_carry, out_zero, out_neg}), 32'b100);
    out_ready = 1'b1;
    tick("left.pop");

    drive(8'h81, 8'hF0, 3'd3, 1'b0, 1'b1, 4'd9);
    out_ready = 1'b0;
    tick("arith");
    idle();
    check("arith.flags", 32'({out_carry, out_zero, out_neg}), 32'b001);
    out_ready = 1'b1;
    tick("arith.pop");
    drive(8'hFF, 8'hFF, 3'd0, 1'b0, 1'b1, 4'd2);
    out_ready = 1'b0;
    tick("amt0");
    idle();
    check("amt0.carry", 32'(out_carry), 32'd0);
    out_ready = 1'b1;
    tick("amt0.pop");

    out_ready = 1'b0;
    drive(8'h11, 8'h11, 3'd0, 1'b1, 1'b0, 4'd1);
    tick("bp1");
    drive(8'h22, 8'h22, 3'd0, 1'b1, 1'b0, 4'd2);
    tick("bp2");
    drive(8'h33, 8'h33, 3'd0, 1'b1, 1'b0, 4'd3);
    check("bp.full_ready", 32'(in_ready), 32'd0);
    tick("bp3");
    tick("bp4");
    check("bp.hold", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    tick("bp.drain1");
    check("bp.second", 32'(out_data), 32'h22);
    tick("bp.drain2");
    idle();
    check("bp.third", 32'(out_data), 32'h33);
    tick("bp.drain3");
    check("bp.empty", 32'(out_valid), 32'd0);

    for (int i = 0; i < 200; i++) begin
      op  = 8'($urandom_range(0, 255));
      amt = 3'($urandom_range(0, 7));
      lf  = 1'($urandom_range(0, 1));
      ar  = 1'($urandom_range(0, 1));
      if (lf)      res = op << amt;
      else if (ar) res = 8'($signed(op) >>> amt);
      else         res = op >> amt;
      if (($urandom_range(0, 7)) == 0) res = 8'h00;
      drive(op, res, amt, lf, ar, 4'($urandom_range(0, 15)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick("rand");
    end

    idle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick("pre_flush");
    while (exp_q.size() < DEPTH) begin
      drive(8'h5A, 8'hA5, 3'd1, 1'b0, 1'b0, 4'd7);
      tick("fill");
    end
    drive(8'hC3, 8'hEE, 3'd2, 1'b1, 1'b0, 4'd6);
    for (int i = 0; i < 3; i++) tick("refill");
    flush = 1'b1;
    out_ready = 1'b1;
    drive(8'h77, 8'h77, 3'd0, 1'b1, 1'b0, 4'd4);
    tick("flush");
    flush = 1'b0;
    idle();
    check("flush.out_valid", 32'(out_valid), 32'd0);
    check("flush.in_ready", 32'(in_ready), 32'd1);
    tick("post_flush");
    check("post_flush.valid", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    drive(8'h12, 8'h34, 3'd4, 1'b1, 1'b0, 4'd3);
    tick("mid1");
    tick("mid2");
    reset = 1'b1;
    idle();
    tick("mid_reset");
    reset = 1'b0;
    #1;
    check("mid_reset.out_valid", 32'(out_valid), 32'd0);
    check("mid_reset.out_data", 32'(out_data), 32'h00);
    check("mid_reset.in_ready", 32'(in_ready), 32'd1);
    tick("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
